memory_access_sequencer: RTL

MEMORY_ACCESS_SEQUENCER -- requirements
Module: memory_access_sequencer

---
 rtl/memory_access_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/memory_access_sequencer.sv
// Arbitrates core and debug memory requests onto one memory controller and
// walks each access through a check phase so faulty stores never write.
`timescale 1ns/1ps

package memory_access_sequencer_pkg;
  typedef enum logic [1:0] {
    NOP           = 2'd0,
    LOAD          = 2'd1,
    STORE_PRELOAD = 2'd2,
    STORE         = 2'd3
  } MemoryMode_t;
endpackage

module memory_access_sequencer
  import memory_access_sequencer_pkg::*;
#(
  parameter bit DEBUG_HAS_PRIORITY = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              coreRequest,
  input  logic              coreIsStore,
  input  logic [2:0]        coreFunct3,
  input  logic [31:0]       coreRs1,
  input  logic [31:0]       coreImmediate,
  input  logic [31:0]       coreRs2,
  output logic              coreDone,
  output logic              coreError,
  input  logic              debugRequest,
  input  logic              debugIsStore,
  input  logic [2:0]        debugFunct3,
  input  logic [31:0]       debugAddress,
  input  logic [31:0]       debugWriteData,
  output logic              debugDone,
  output logic              debugError,
  output logic [31:0]       readData,
  output MemoryMode_t       memoryMode,
  output logic [2:0]        memFunct3,
  output logic [31:0]       memRs1,
  output logic [31:0]       memImmediateI,
  output logic [31:0]       memImmediateS,
  output logic [31:0]       memRs2,
  input  logic [31:0]       memoryOutput,
  input  logic              memoryUnalignedAccess,
  input  logic              memoryBadFunct3
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_ISSUE,
    LOAD_CAPTURE,
    STORE_CHECK,
    STORE_WRITE
  } State_t;

  State_t state;
  logic   lastGrantDebug;
  logic   ownerDebug;
  logic   grantAny;
  logic   grantDebug;
  logic   grantIsStore;
  logic   accessError;
  logic   opEnd;
  logic   opError;

  assign accessError = memoryUnalignedAccess | memoryBadFunct3;

  // On a tie, round-robin hands the grant to whoever was not served last.
  always_comb begin
    grantAny   = coreRequest | debugRequest;
    grantDebug = debugRequest;
    if (coreRequest && debugRequest) begin
      grantDebug = DEBUG_HAS_PRIORITY ? 1'b1 : ~lastGrantDebug;
    end
    grantIsStore = grantDebug ? debugIsStore : coreIsStore;
  end

  always_comb begin
    opEnd   = 1'b0;
    opError = 1'b0;
    case (state)
      LOAD_ISSUE, STORE_CHECK: begin
        opEnd   = accessError;
        opError = accessError;
      end
      LOAD_CAPTURE, STORE_WRITE: opEnd = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      memoryMode     <= NOP;
      coreDone       <= 1'b0;
      coreError      <= 1'b0;
      debugDone      <= 1'b0;
      debugError     <= 1'b0;
      readData       <= 32'd0;
      memFunct3      <= 3'd0;
      memRs1         <= 32'd0;
      memImmediateI  <= 32'd0;
      memImmediateS  <= 32'd0;
      memRs2         <= 32'd0;
      lastGrantDebug <= 1'b1;
      ownerDebug     <= 1'b0;
    end else begin
      coreDone   <= opEnd & ~ownerDebug;
      coreError  <= opError & ~ownerDebug;
      debugDone  <= opEnd & ownerDebug;
      debugError <= opError & ownerDebug;

      case (state)
        IDLE: begin
          if (grantAny) begin
            ownerDebug     <= grantDebug;
            lastGrantDebug <= grantDebug;
            if (grantDebug) begin
              memFunct3     <= debugFunct3;
              memRs1        <= debugAddress;
              memImmediateI <= 32'd0;
              memImmediateS <= 32'd0;
              memRs2        <= debugWriteData;
            end else begin
              memFunct3     <= coreFunct3;
              memRs1        <= coreRs1;
              memImmediateI <= coreImmediate;
              memImmediateS <= coreImmediate;
              memRs2        <= coreRs2;
            end
            if (grantIsStore) begin
              state      <= STORE_CHECK;
              memoryMode <= STORE_PRELOAD;
            end else begin
              state      <= LOAD_ISSUE;
              memoryMode <= LOAD;
            end
          end
        end
        LOAD_ISSUE: begin
          if (accessError) begin
            state      <= IDLE;
            memoryMode <= NOP;
          end else begin
            state      <= LOAD_CAPTURE;
            memoryMode <= LOAD;
          end
        end
        // The controller returns little-endian words; the requesters expect big-endian.
        LOAD_CAPTURE: begin
          readData   <= {memoryOutput[7:0], memoryOutput[15:8],
                         memoryOutput[23:16], memoryOutput[31:24]};
          state      <= IDLE;
          memoryMode <= NOP;
        end
        STORE_CHECK: begin
          if (accessError) begin
            state      <= IDLE;
            memoryMode <= NOP;
          end else begin
            state      <= STORE_WRITE;
            memoryMode <= STORE;
          end
        end
        STORE_WRITE: begin
          state      <= IDLE;
          memoryMode <= NOP;
        end
        default: begin
          state      <= IDLE;
          memoryMode <= NOP;
        end
      endcase
    end
  end

endmodule
